// File: rtl/run_controller_pkg.sv
// rtl/run_controller_pkg.sv - shared types and constants for the fetch run controller
package run_controller_pkg;

    localparam int P_WIDTH = 16;
    localparam int unsigned RUN_MAX_CYCLES = 4000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } run_state_t;

endpackage

// File: rtl/run_controller_counter.sv
// rtl/run_controller_counter.sv - clearable enabled up-counter used for cycle and instruction counts
module run_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + WIDTH'(1);
        end
    end

endmodule

// File: rtl/run_controller.sv
// rtl/run_controller.sv - run-control sequencer: clears, releases, freezes and reports the fetch PC
module run_controller
    import run_controller_pkg::*;
#(
    parameter int          CYCLE_WIDTH = 16,
    parameter int unsigned MAX_CYCLES  = RUN_MAX_CYCLES
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   go,
    input  logic                   halt,
    input  logic                   stall_req,
    input  logic [P_WIDTH-1:0]     pc_in,
    output logic                   fetch_reset,
    output logic                   fetch_hold,
    output logic                   done,
    output logic                   timeout,
    output logic [CYCLE_WIDTH-1:0] cycle_count,
    output logic [CYCLE_WIDTH-1:0] instr_count,
    output logic [P_WIDTH-1:0]     end_pc
);

    localparam logic [CYCLE_WIDTH-1:0] LAST_CYCLE = CYCLE_WIDTH'(MAX_CYCLES - 1);

    run_state_t state;
    logic       in_run;
    logic       in_clear;
    logic       accept_halt;
    logic       watchdog;

    assign in_run      = (state == RUN);
    assign in_clear    = (state == CLEAR);
    // A halt seen while stalled belongs to an instruction that is not yet valid.
    assign accept_halt = in_run && halt && !stall_req;
    assign watchdog    = in_run && (cycle_count == LAST_CYCLE);

    assign fetch_reset = in_clear;
    assign fetch_hold  = in_run ? stall_req : 1'b1;
    assign done        = (state == DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            timeout <= 1'b0;
            end_pc  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (go) state <= CLEAR;
                end
                CLEAR: begin
                    timeout <= 1'b0;
                    end_pc  <= '0;
                    state   <= RUN;
                end
                RUN: begin
                    if (accept_halt) begin
                        end_pc <= pc_in;
                        state  <= DONE;
                    end else if (watchdog) begin
                        timeout <= 1'b1;
                        end_pc  <= pc_in;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    // Requiring go to fall prevents an automatic restart.
                    if (!go) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    run_counter #(.WIDTH(CYCLE_WIDTH)) u_cycle_counter (
        .clk   (clk),
        .reset (reset),
        .clear (in_clear),
        .en    (in_run),
        .count (cycle_count)
    );

    run_counter #(.WIDTH(CYCLE_WIDTH)) u_instr_counter (
        .clk   (clk),
        .reset (reset),
        .clear (in_clear),
        .en    (in_run && !stall_req),
        .count (instr_count)
    );

endmodule

// File: tb/tb_run_controller.sv
// tb/tb_run_controller.sv - randomized bench for run_controller against a behavioural run model
module tb_run_controller;

    localparam int PW   = run_controller_pkg::P_WIDTH;
    localparam int CW   = 16;
    localparam int MAXC = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic          halt = 1'b0;
    logic          stall_req = 1'b0;
    logic [PW-1:0] pc = '0;
    logic          fetch_reset;
    logic          fetch_hold;
    logic          done;
    logic          timeout;
    logic [CW-1:0] cycle_count;
    logic [CW-1:0] instr_count;
    logic [PW-1:0] end_pc;

    int tests = 0;
    int fails = 0;
    int fr_pulses = 0;
    int done_seen = 0;
    bit armed = 1'b0;

    // Model: 0 idle, 1 clear, 2 running, 3 finished
    int m_phase = 0;
    int m_cyc = 0;
    int m_ins = 0;
    int m_end = 0;
    int m_to = 0;
    int m_pc = 0;

    always #5 clk = ~clk;

    run_controller #(.CYCLE_WIDTH(CW), .MAX_CYCLES(MAXC)) dut (
        .clk         (clk),
        .reset       (reset),
        .go          (go),
        .halt        (halt),
        .stall_req   (stall_req),
        .pc_in       (pc),
        .fetch_reset (fetch_reset),
        .fetch_hold  (fetch_hold),
        .done        (done),
        .timeout     (timeout),
        .cycle_count (cycle_count),
        .instr_count (instr_count),
        .end_pc      (end_pc)
    );

    // Fetch unit stand-in driven by the DUT's reset/hold outputs.
    always @(posedge clk) begin
        if (reset || fetch_reset) pc <= '0;
        else if (!fetch_hold) pc <= pc + 1'b1;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_phase = 0; m_cyc = 0; m_ins = 0; m_end = 0; m_to = 0; m_pc = 0;
        end else begin
            case (m_phase)
                0: if (go) m_phase = 1;
                1: begin
                    m_cyc = 0; m_ins = 0; m_end = 0; m_to = 0; m_pc = 0;
                    m_phase = 2;
                end
                2: begin
                    if (halt && !stall_req) begin
                        m_end = m_pc; m_phase = 3;
                    end else if (m_cyc == MAXC - 1) begin
                        m_end = m_pc; m_to = 1; m_phase = 3;
                    end
                    m_cyc = m_cyc + 1;
                    if (!stall_req) begin
                        m_ins = m_ins + 1;
                        m_pc = m_pc + 1;
                    end
                end
                default: if (!go) m_phase = 0;
            endcase
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (fetch_reset === 1'b1) fr_pulses++;
        if (done === 1'b1) done_seen++;
        if (armed) begin
            check("fetch_reset", 32'(fetch_reset), 32'(m_phase == 1));
            check("fetch_hold", 32'(fetch_hold), 32'((m_phase != 2) || stall_req));
            check("done", 32'(done), 32'(m_phase == 3));
            check("timeout", 32'(timeout), 32'(m_to));
            check("cycle_count", 32'(cycle_count), 32'(m_cyc));
            check("instr_count", 32'(instr_count), 32'(m_ins));
            check("end_pc", 32'(end_pc), 32'(m_end));
            check("pc_in", 32'(pc), 32'(m_pc));
            check("instr_le_cycle", 32'(instr_count <= cycle_count), 32'd1);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_prog(input logic [63:0] hm, input logic [63:0] sm);
        go = 1'b0; tick();
        go = 1'b1; tick();
        fr_pulses = 0;
        check("clear_fetch_reset", 32'(fetch_reset), 32'd1);
        go = 1'b0; tick();
        check("run1_cycles", 32'(cycle_count), 32'd0);
        check("run1_pc", 32'(pc), 32'd0);
        for (int k = 1; k <= 40; k++) begin
            if (m_phase != 2) break;
            halt = hm[k];
            stall_req = sm[k];
            tick();
        end
        halt = 1'b0;
        stall_req = 1'b0;
        check("run_bound", 32'(done), 32'd1);
    endtask

    initial begin
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        armed = 1'b1;
        check("rst_hold", 32'(fetch_hold), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_cycles", 32'(cycle_count), 32'd0);

        run_prog(64'd1 << 6, 64'd0);
        check("basic_fr_pulses", 32'(fr_pulses), 32'd1);
        check("basic_cycles", 32'(cycle_count), 32'd6);
        check("basic_instrs", 32'(instr_count), 32'd6);
        check("basic_end_pc", 32'(end_pc), 32'd5);
        check("basic_timeout", 32'(timeout), 32'd0);

        run_prog(64'd1 << 8, (64'd1 << 2) | (64'd1 << 3));
        check("stall_cycles", 32'(cycle_count), 32'd8);
        check("stall_instrs", 32'(instr_count), 32'd6);
        check("stall_end_pc", 32'(end_pc), 32'd5);

        run_prog((64'd1 << 4) | (64'd1 << 5), 64'd1 << 4);
        check("hstall_cycles", 32'(cycle_count), 32'd5);
        check("hstall_instrs", 32'(instr_count), 32'd4);
        check("hstall_end_pc", 32'(end_pc), 32'd3);

        run_prog(64'd0, 64'd0);
        check("wd_timeout", 32'(timeout), 32'd1);
        check("wd_cycles", 32'(cycle_count), 32'd10);
        check("wd_end_pc", 32'(end_pc), 32'd9);

        run_prog(64'd1 << 10, 64'd0);
        check("htmo_timeout", 32'(timeout), 32'd0);
        check("htmo_cycles", 32'(cycle_count), 32'd10);

        go = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rearm_hold_done", 32'(done), 32'd1);
        end
        go = 1'b0; tick();
        check("rearm_idle", 32'(done), 32'd0);
        run_prog(64'd1 << 3, 64'd0);
        check("rearm_cycles", 32'(cycle_count), 32'd3);
        check("rearm_end_pc", 32'(end_pc), 32'd2);

        go = 1'b0; tick();
        go = 1'b1; tick();
        go = 1'b0; tick();
        tick(); tick();
        done_seen = 0;
        reset = 1'b1; tick();
        reset = 1'b0;
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_hold", 32'(fetch_hold), 32'd1);
        check("midrst_fr", 32'(fetch_reset), 32'd0);
        check("midrst_cycles", 32'(cycle_count), 32'd0);
        check("midrst_instrs", 32'(instr_count), 32'd0);
        tick(); tick();
        check("midrst_no_done", 32'(done_seen), 32'd0);

        for (int n = 0; n < 30; n++) begin
            logic [63:0] sm;
            logic [63:0] hm;
            sm = {$urandom, $urandom} & {$urandom, $urandom};
            hm = (64'd1 << $urandom_range(1, 14)) | (sm & {$urandom, $urandom});
            if ($urandom_range(0, 5) == 0) hm = sm;
            run_prog(hm, sm);
            go = 1'b1;
            repeat ($urandom_range(0, 3)) tick();
        end
        go = 1'b0;
        tick(); tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
